// File: rtl/i2c_write_scheduler.sv
// rtl/i2c_write_scheduler.sv - two-requester write queue that feeds an I2C init engine one word at a time
// Round-robin between queues A and B; each transaction is start-checked, done/timeout-checked, then gapped.
module i2c_write_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int START_WAIT   = 16,
    parameter int DONE_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        init_write,
    output logic [31:0] init_data,
    input  logic        init_busy,
    output logic        done,
    output logic        err_start,
    output logic        err_timeout,
    output logic        grant_b,
    output logic [3:0]  pending
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [15:0]   START_LIM = 16'(START_WAIT - 1);
    localparam logic [15:0]   DONE_LIM  = 16'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t state, state_nxt;
    logic [15:0] timer;
    logic        pop;
    logic        sel;

    logic [31:0]   mem_a [FIFO_DEPTH];
    logic [31:0]   mem_b [FIFO_DEPTH];
    logic [PW-1:0] wr_a, rd_a, wr_b, rd_b;
    logic [CW-1:0] cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
    logic          push_a, push_b, pop_a, pop_b;

    assign a_ready = !rst && (cnt_a < DEPTH_C);
    assign b_ready = !rst && (cnt_b < DEPTH_C);
    assign push_a  = a_valid && a_ready;
    assign push_b  = b_valid && b_ready;
    assign pop_a   = pop && !sel;
    assign pop_b   = pop && sel;

    assign cnt_a_nxt = cnt_a + CW'(push_a) - CW'(pop_a);
    assign cnt_b_nxt = cnt_b + CW'(push_b) - CW'(pop_b);

    // Storage carries no reset; emptiness is tracked purely by the counters.
    always_ff @(posedge clk) begin
        if (push_a) mem_a[wr_a] <= a_data;
        if (push_b) mem_b[wr_b] <= b_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_a    <= '0;
            rd_a    <= '0;
            wr_b    <= '0;
            rd_b    <= '0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            pending <= '0;
        end else begin
            if (push_a) wr_a <= wr_a + PW'(1);
            if (pop_a)  rd_a <= rd_a + PW'(1);
            if (push_b) wr_b <= wr_b + PW'(1);
            if (pop_b)  rd_b <= rd_b + PW'(1);
            cnt_a   <= cnt_a_nxt;
            cnt_b   <= cnt_b_nxt;
            pending <= 4'({1'b0, cnt_a_nxt} + {1'b0, cnt_b_nxt});
        end
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        init_write  = 1'b0;
        done        = 1'b0;
        err_start   = 1'b0;
        err_timeout = 1'b0;
        // With only one queue occupied it wins; with both, the one not served last.
        if (cnt_a == '0)      sel = 1'b1;
        else if (cnt_b == '0) sel = 1'b0;
        else                  sel = !grant_b;

        case (state)
            IDLE: begin
                if (!init_busy && (cnt_a != '0 || cnt_b != '0)) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                init_write = 1'b1;
                state_nxt  = WAIT_START;
            end
            WAIT_START: begin
                if (init_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (timer >= START_LIM) begin
                    err_start = 1'b1;
                    state_nxt = GAP;
                end
            end
            WAIT_DONE: begin
                if (!init_busy) begin
                    done      = 1'b1;
                    state_nxt = GAP;
                end else if (timer >= DONE_LIM) begin
                    err_timeout = 1'b1;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                if (timer == 16'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (rst) begin
            pop         = 1'b0;
            init_write  = 1'b0;
            done        = 1'b0;
            err_start   = 1'b0;
            err_timeout = 1'b0;
        end
    end

    // One shared timer restarts on every state change; GAP reuses it to count its two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            init_data <= '0;
            grant_b   <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)  timer <= '0;
            else if (timer != 16'hFFFF) timer <= timer + 16'd1;
            if (pop) begin
                init_data <= sel ? mem_b[rd_b] : mem_a[rd_a];
                grant_b   <= sel;
            end
        end
    end

endmodule

// File: tb/tb_i2c_write_scheduler.sv
// tb/tb_i2c_write_scheduler.sv - directed self-checking bench for i2c_write_scheduler
// An engine model raises busy two cycles after each start pulse; a monitor logs issues and pulses.
module tb_i2c_write_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic [31:0] b_data = '0;
    logic        a_ready, b_ready, init_write, done, err_start, err_timeout, grant_b;
    logic [31:0] init_data;
    logic [3:0]  pending;
    logic        init_busy;
    logic        mbusy = 1'b0;
    logic        hold_busy = 1'b0;

    assign init_busy = mbusy | hold_busy;

    i2c_write_scheduler dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .init_write(init_write), .init_data(init_data), .init_busy(init_busy),
        .done(done), .err_start(err_start), .err_timeout(err_timeout),
        .grant_b(grant_b), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mode = 0;       // 0 normal, 1 never busy, 2 busy forever
    int busy_len = 3;
    int dly = 0;
    int hi = 0;
    int n_done = 0, n_es = 0, n_et = 0, n_excl = 0;
    logic [31:0] iw_word [$];
    int          iw_cyc [$];
    int          es_cyc [$];
    int          et_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: reacts just after each edge so busy is stable well before the next one.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            mbusy = 1'b0;
            dly   = 0;
            hi    = 0;
        end else begin
            if (dly > 0) begin
                dly--;
                if (dly == 0 && mode != 1) begin
                    mbusy = 1'b1;
                    hi    = busy_len;
                end
            end else if (mbusy && mode != 2) begin
                hi--;
                if (hi <= 0) mbusy = 1'b0;
            end
            if (init_write) dly = 2;
        end
    end

    always @(negedge clk) begin
        if (init_write) begin
            iw_word.push_back(init_data);
            iw_cyc.push_back(cyc);
        end
        if (done) n_done++;
        if (err_start) begin
            n_es++;
            es_cyc.push_back(cyc);
        end
        if (err_timeout) begin
            n_et++;
            et_cyc.push_back(cyc);
        end
        if (int'(done) + int'(err_start) + int'(err_timeout) > 1) n_excl++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input logic [31:0] w);
        int n;
        n = 0;
        a_valid = 1'b1;
        a_data  = w;
        while (!a_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("push_a_bound", 32'(n), 0);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic push_ab(input logic [31:0] wa, input logic [31:0] wb);
        check("push_ab_ready", {30'd0, a_ready, b_ready}, 32'd3);
        a_valid = 1'b1;
        a_data  = wa;
        b_valid = 1'b1;
        b_data  = wb;
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_events(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (n_done + n_es + n_et < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n_done + n_es + n_et >= target), 32'd1);
    endtask

    logic [31:0] exp_ab [6];
    logic [31:0] exp_fill [5];
    int base, ev0, es0, et0, r, d, n;

    initial begin
        exp_ab   = '{32'h00A01001, 32'h00B02002, 32'h00A01103, 32'h00B02104, 32'h00A01205, 32'h00B02206};
        exp_fill = '{32'h00300101, 32'h00300202, 32'h00300303, 32'h00300404, 32'h00300505};

        // Reset state
        rst = 1'b1;
        step(3);
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        check("rst_init_write", {31'd0, init_write}, 32'd0);
        check("rst_init_data", init_data, 32'd0);
        check("rst_grant_b", {31'd0, grant_b}, 32'd1);
        rst = 1'b0;
        step(1);
        check("post_rst_ready", {30'd0, a_ready, b_ready}, 32'd3);

        // Single write with a 50-cycle busy engine
        busy_len = 50;
        mode = 0;
        base = iw_word.size();
        push_a(32'h00281C00);
        check("single_pending_1", {28'd0, pending}, 32'd1);
        wait_events(1, 300, "single_event");
        step(3);
        check("single_done", 32'(n_done), 32'd1);
        check("single_issue_cnt", 32'(iw_word.size() - base), 32'd1);
        if (iw_word.size() > base) check("single_word", iw_word[base], 32'h00281C00);
        check("single_init_data_held", init_data, 32'h00281C00);
        check("single_pending_0", {28'd0, pending}, 32'd0);
        check("single_grant_b", {31'd0, grant_b}, 32'd0);

        // Round-robin with simultaneous pushes; reset first so A wins the first tie
        busy_len = 3;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        base = iw_word.size();
        ev0 = n_done + n_es + n_et;
        push_ab(exp_ab[0], exp_ab[1]);
        push_ab(exp_ab[2], exp_ab[3]);
        push_ab(exp_ab[4], exp_ab[5]);
        wait_events(ev0 + 6, 400, "rr_events");
        step(3);
        check("rr_issue_cnt", 32'(iw_word.size() - base), 32'd6);
        for (int i = 0; i < 6; i++)
            if (iw_word.size() > base + i) check($sformatf("rr_order_%0d", i), iw_word[base + i], exp_ab[i]);

        // Queue full back-pressure: engine held busy so nothing drains
        hold_busy = 1'b1;
        base = iw_word.size();
        ev0 = n_done + n_es + n_et;
        for (int i = 0; i < 4; i++) push_a(exp_fill[i]);
        check("full_a_ready", {31'd0, a_ready}, 32'd0);
        check("full_pending", {28'd0, pending}, 32'd4);
        a_valid = 1'b1;
        a_data  = exp_fill[4];
        step(3);
        check("full_held_ready", {31'd0, a_ready}, 32'd0);
        check("full_held_pending", {28'd0, pending}, 32'd4);
        check("full_no_issue", 32'(iw_word.size() - base), 32'd0);
        hold_busy = 1'b0;
        n = 0;
        while (!a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("full_ready_after_pop", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        check("full_pending_refill", {28'd0, pending}, 32'd4);
        wait_events(ev0 + 5, 400, "full_events");
        step(3);
        for (int i = 0; i < 5; i++)
            if (iw_word.size() > base + i) check($sformatf("full_order_%0d", i), iw_word[base + i], exp_fill[i]);

        // Engine never starts: err_start 16 cycles after the pulse, next word right after the gap
        mode = 1;
        base = iw_word.size();
        ev0 = n_done + n_es + n_et;
        es0 = n_es;
        push_a(32'h00111111);
        push_a(32'h00222222);
        wait_events(ev0 + 2, 200, "nostart_events");
        step(3);
        check("nostart_err_cnt", 32'(n_es - es0), 32'd2);
        if (es_cyc.size() > es0 && iw_cyc.size() > base + 1) begin
            check("nostart_latency", 32'(es_cyc[es0] - iw_cyc[base]), 32'd16);
            check("nostart_next_issue", 32'(iw_cyc[base + 1] - es_cyc[es0]), 32'd4);
            check("nostart_second_word", iw_word[base + 1], 32'h00222222);
        end else begin
            check("nostart_logged", 32'd0, 32'd1);
        end
        mode = 0;

        // Busy in IDLE blocks the issue until it falls
        hold_busy = 1'b1;
        base = iw_word.size();
        ev0 = n_done + n_es + n_et;
        push_a(32'h00444444);
        step(10);
        check("busy_idle_no_issue", 32'(iw_word.size() - base), 32'd0);
        r = cyc;
        hold_busy = 1'b0;
        n = 0;
        while (iw_word.size() == base && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (iw_word.size() > base) begin
            d = iw_cyc[base] - r;
            check("busy_idle_issue_delay", 32'(d >= 1 && d <= 2), 32'd1);
        end else begin
            check("busy_idle_issued", 32'd0, 32'd1);
        end
        wait_events(ev0 + 1, 100, "busy_idle_event");
        step(3);

        // Reset in the middle of WAIT_DONE abandons the transaction and the queue
        mode = 2;
        base = iw_word.size();
        push_a(32'h00555555);
        step(10);
        push_a(32'h00666666);
        check("midrst_pending_before", {28'd0, pending}, 32'd1);
        rst = 1'b1;
        step(2);
        mode = 0;
        rst = 1'b0;
        step(30);
        check("midrst_no_issue", 32'(iw_word.size() - base), 32'd1);
        check("midrst_pending", {28'd0, pending}, 32'd0);
        check("midrst_grant_b", {31'd0, grant_b}, 32'd1);
        check("midrst_init_data", init_data, 32'd0);

        // Busy stuck high: err_timeout after the full 65535-cycle window in WAIT_DONE
        mode = 2;
        base = iw_word.size();
        et0 = n_et;
        push_a(32'h00777777);
        n = 0;
        while (n_et == et0 && n < 70000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cnt", 32'(n_et - et0), 32'd1);
        if (et_cyc.size() > et0 && iw_cyc.size() > base)
            check("timeout_latency", 32'(et_cyc[et0] - iw_cyc[base]), 32'd65537);
        rst = 1'b1;
        step(2);
        mode = 0;
        rst = 1'b0;
        step(2);

        check("pulse_exclusive", 32'(n_excl), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
